// File: rtl/prover_round_seq.sv
// Sumcheck prover round sequencer: walks npoints phase-1 rounds then npoints
// phase-2 rounds, one per valid/ready handshake, with registered round masks.
module prover_round_seq #(
   parameter  int npoints = 5,
   localparam int RW      = $clog2(npoints) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               rnd_ready,
   output logic               rnd_valid,
   output logic               phase2,
   output logic [RW-1:0]      round_num,
   output logic [npoints-1:0] round_rev,
   output logic [npoints-1:0] rnd_mask,
   output logic [npoints-1:0] rn2_mask,
   output logic               last_round,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {S_IDLE, S_P1, S_P2, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [RW-1:0]   w_r_nxt;
   logic            w_hs;
   logic            w_last_r;

   // Shift at npoints+1 bits so that r == npoints would still yield all ones.
   function automatic logic [npoints-1:0] thermo(input logic [RW-1:0] r);
      logic [npoints:0] t;
      t = ((npoints+1)'(1) << r) - (npoints+1)'(1);
      return t[npoints-1:0];
   endfunction

   function automatic logic [npoints-1:0] bitrev(input logic [RW-1:0] r);
      logic [npoints-1:0] e;
      logic [npoints-1:0] v;
      e = npoints'(r);
      for (int i = 0; i < npoints; i++) v[i] = e[npoints-1-i];
      return v;
   endfunction

   assign w_hs     = rnd_valid & rnd_ready;
   assign w_last_r = (round_num == RW'(npoints - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // round_num doubles as the round counter; it is zero outside P1/P2.
   always_comb begin
      w_state_nxt = r_state;
      w_r_nxt     = round_num;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_P1;
               w_r_nxt     = '0;
            end
         end
         S_P1: begin
            if (w_hs) begin
               if (w_last_r) begin
                  w_state_nxt = S_P2;
                  w_r_nxt     = '0;
               end else begin
                  w_r_nxt = round_num + RW'(1);
               end
            end
         end
         S_P2: begin
            if (w_hs) begin
               if (w_last_r) begin
                  w_state_nxt = S_DONE;
                  w_r_nxt     = '0;
               end else begin
                  w_r_nxt = round_num + RW'(1);
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_r_nxt     = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_r_nxt     = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk) begin
      if (rst) begin
         rnd_valid  <= 1'b0;
         phase2     <= 1'b0;
         round_num  <= '0;
         round_rev  <= '0;
         rnd_mask   <= '0;
         rn2_mask   <= '1;
         last_round <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         rnd_valid  <= (w_state_nxt == S_P1) || (w_state_nxt == S_P2);
         phase2     <= (w_state_nxt == S_P2);
         round_num  <= w_r_nxt;
         round_rev  <= bitrev(w_r_nxt);
         rnd_mask   <= (w_state_nxt == S_P1) ? thermo(w_r_nxt) :
                       (w_state_nxt == S_P2) ? '1 : '0;
         rn2_mask   <= (w_state_nxt == S_P2) ? ~thermo(w_r_nxt) : '1;
         last_round <= (w_state_nxt == S_P2) && (w_r_nxt == RW'(npoints - 1));
         busy       <= (w_state_nxt != S_IDLE);
         done       <= (w_state_nxt == S_DONE);
      end
   end

endmodule
